seq_detector_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 4-bit `seqDetector` in the Lab 3 sequential-logic set. It samples a qualified 1-bit stream and flags each occurrence of a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable, and a saturating counter tracks matches. It sits between a bit-serial source and downstream logic that consumes one-cycle match pulses.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_hist.sv | 50 +++++
 rtl/seq_detector_param.sv | 133 +++++++++++++
 tb/tb_seq_detector_param.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Imported by the history sub-module and the detector top.
package seq_det_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [7:0] DEF_PAT = 8'b0000_1011;
   localparam int         DEF_LEN = 4;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register plus a fill counter that saturates at len.
// full_next is high when one more accepted bit makes the window complete.
module seq_det_hist
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               shift,
   input  logic               restart,
   input  logic               din,
   input  logic [LEN_W-1:0]   len,
   output logic [MAX_LEN-1:0] hist,
   output logic               full_next
);

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;

   // restart wins over shift: the bit that triggered it is not kept
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (restart) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift) begin
         hist_d = {hist_q[MAX_LEN-2:0], din};
         if (fill_q != len) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   assign hist      = hist_q;
   assign full_next = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len};

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control
// and a saturating match counter; all outputs are registered.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEF_PAT),
   parameter int                 DEFAULT_LEN = DEF_LEN,
   localparam int                LEN_W       = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               inp,
   input  logic               overlap,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               clear,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err,
   output logic               state
);

   state_e             st_q, st_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               match_q, match_d;
   logic               err_q, err_d;

   logic               shift;
   logic               restart;
   logic               full_next;
   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] win;
   logic [MAX_LEN-1:0] mask;
   logic               hit;
   logic               cfg_ok;
   logic               unused_msb;

   seq_det_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .shift     (shift),
      .restart   (restart),
      .din       (inp),
      .len       (len_q),
      .hist      (hist),
      .full_next (full_next)
   );

   // compare against the window as it looks once inp has shifted in
   assign win        = {hist[MAX_LEN-2:0], inp};
   assign unused_msb = hist[MAX_LEN-1];

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = LEN_W'(i) < len_q;
      end
   end

   assign hit    = ((win ^ pat_q) & mask) == '0;
   assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   always_comb begin
      st_d    = st_q;
      pat_d   = pat_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;
      err_d   = cfg_load && !cfg_ok;
      shift   = 1'b0;
      restart = 1'b0;
      if (clear) begin
         restart = 1'b1;
         cnt_d   = '0;
         st_d    = ST_FILL;
      end else if (cfg_load && cfg_ok) begin
         pat_d   = cfg_pat;
         len_d   = cfg_len;
         restart = 1'b1;
         st_d    = ST_FILL;
      end else if (in_valid) begin
         shift = 1'b1;
         unique case (st_q)
            ST_FILL: st_d = full_next ? ST_RUN : ST_FILL;
            ST_RUN:  st_d = ST_RUN;
         endcase
         if (full_next && hit) begin
            match_d = 1'b1;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // non-overlapping: matched bits may not seed the next match
            if (!overlap) begin
               restart = 1'b1;
               st_d    = ST_FILL;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= ST_FILL;
         pat_q   <= DEFAULT_PAT;
         len_q   <= LEN_W'(DEFAULT_LEN);
         cnt_q   <= '0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         err_q   <= err_d;
      end
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = err_q;
   assign state     = st_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default and CNT_W=2 instances
// share one stimulus stream; expectations are hand-derived constants.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       inp;
   logic       overlap;
   logic       cfg_load;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic       clear;

   logic       match, cfg_err, state;
   logic [7:0] match_cnt;
   logic       match2, cfg_err2, state2;
   logic [1:0] match_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_detector_param dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inp       (inp),
      .overlap   (overlap),
      .cfg_load  (cfg_load),
      .cfg_pat   (cfg_pat),
      .cfg_len   (cfg_len),
      .clear     (clear),
      .match     (match),
      .match_cnt (match_cnt),
      .cfg_err   (cfg_err),
      .state     (state)
   );

   seq_detector_param #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inp       (inp),
      .overlap   (overlap),
      .cfg_load  (cfg_load),
      .cfg_pat   (cfg_pat),
      .cfg_len   (cfg_len),
      .clear     (clear),
      .match     (match2),
      .match_cnt (match_cnt2),
      .cfg_err   (cfg_err2),
      .state     (state2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] bits, input int n,
                       output logic [15:0] mv);
      mv = '0;
      for (int i = n - 1; i >= 0; i--) begin
         in_valid = 1'b1;
         inp      = bits[i];
         tick();
         mv = {mv[14:0], match};
      end
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({match, cfg_err, state} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {match, cfg_err, state});
      end
      checks++;
      if (match_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d exp=0", match_cnt);
      end
      checks++;
      if ({match2, cfg_err2, state2, match_cnt2} !== 5'b0) begin
         failures++;
         $display("FAIL reset_dut2 got=%b exp=00000",
                  {match2, cfg_err2, state2, match_cnt2});
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_default();
      logic [15:0] mv;
      overlap = 1'b1;
      send(16'b1011_0000_1011_0000, 16, mv);
      checks++;
      if (mv !== 16'b0001_0000_0001_0000) begin
         failures++;
         $display("FAIL default_match got=%b exp=0001000000010000", mv);
      end
      checks++;
      if (match_cnt !== 8'd2) begin
         failures++;
         $display("FAIL default_cnt got=%0d exp=2", match_cnt);
      end
   endtask

   task automatic test_overlap();
      logic [15:0] mv;
      do_clear();
      overlap = 1'b1;
      send(16'b1011011, 7, mv);
      checks++;
      if (mv[6:0] !== 7'b0001001 || match_cnt !== 8'd2 || state !== 1'b1) begin
         failures++;
         $display("FAIL overlap_on got=%b cnt=%0d st=%b exp=0001001 cnt=2 st=1",
                  mv[6:0], match_cnt, state);
      end
      do_clear();
      overlap = 1'b0;
      send(16'b1011011, 7, mv);
      checks++;
      if (mv[6:0] !== 7'b0001000 || match_cnt !== 8'd1 || state !== 1'b0) begin
         failures++;
         $display("FAIL overlap_off got=%b cnt=%0d st=%b exp=0001000 cnt=1 st=0",
                  mv[6:0], match_cnt, state);
      end
      overlap = 1'b1;
   endtask

   task automatic test_gaps();
      logic [3:0] bits;
      bits = 4'b1011;
      do_clear();
      for (int i = 3; i >= 0; i--) begin
         in_valid = 1'b1;
         inp      = bits[i];
         tick();
         checks++;
         if (match !== (i == 0)) begin
            failures++;
            $display("FAIL gap_bit%0d got=%b exp=%b", 3 - i, match, i == 0);
         end
         for (int g = 0; g < 3; g++) begin
            in_valid = 1'b0;
            inp      = ~bits[i];
            tick();
            checks++;
            if (match !== 1'b0) begin
               failures++;
               $display("FAIL gap_idle%0d_%0d got=%b exp=0", 3 - i, g, match);
            end
         end
      end
      checks++;
      if (match_cnt !== 8'd1 || state !== 1'b1) begin
         failures++;
         $display("FAIL gap_end cnt=%0d st=%b exp cnt=1 st=1", match_cnt, state);
      end
   endtask

   task automatic test_cfg();
      logic [15:0] mv;
      do_clear();
      cfg_load = 1'b1;
      cfg_pat  = 8'hFF;
      cfg_len  = 4'd0;
      in_valid = 1'b1;
      inp      = 1'b1;
      tick();
      checks++;
      if (cfg_err !== 1'b1 || state !== 1'b0) begin
         failures++;
         $display("FAIL cfg_len0 err=%b st=%b exp err=1 st=0", cfg_err, state);
      end
      cfg_len = 4'd9;
      inp     = 1'b0;
      tick();
      checks++;
      if (cfg_err !== 1'b1 || match !== 1'b0) begin
         failures++;
         $display("FAIL cfg_len9 err=%b m=%b exp err=1 m=0", cfg_err, match);
      end
      cfg_load = 1'b0;
      send(16'b11, 2, mv);
      checks++;
      if (mv[1:0] !== 2'b01 || cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL cfg_keep got=%b err=%b exp=01 err=0", mv[1:0], cfg_err);
      end
      cfg_load = 1'b1;
      cfg_pat  = 8'b0011_0011;
      cfg_len  = 4'd6;
      in_valid = 1'b1;
      inp      = 1'b0;
      tick();
      cfg_load = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b0 || state !== 1'b0 || match !== 1'b0) begin
         failures++;
         $display("FAIL cfg_load6 err=%b st=%b m=%b exp 0 0 0",
                  cfg_err, state, match);
      end
      send(16'b110011, 6, mv);
      checks++;
      if (mv[5:0] !== 6'b000001 || match_cnt !== 8'd2) begin
         failures++;
         $display("FAIL cfg_pat6 got=%b cnt=%0d exp=000001 cnt=2",
                  mv[5:0], match_cnt);
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      overlap  = 1'b1;
      cfg_load = 1'b1;
      cfg_pat  = 8'b0000_0001;
      cfg_len  = 4'd1;
      tick();
      cfg_load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         inp      = 1'b1;
         tick();
         checks++;
         if (match !== 1'b1 || match2 !== 1'b1 || state !== 1'b1) begin
            failures++;
            $display("FAIL b2b_match%0d m=%b m2=%b st=%b exp 1 1 1",
                     i, match, match2, state);
         end
         checks++;
         if (match_cnt !== 8'(i + 1) || match_cnt2 !== 2'(i < 3 ? i + 1 : 3)) begin
            failures++;
            $display("FAIL b2b_cnt%0d got=%0d/%0d exp=%0d/%0d", i, match_cnt,
                     match_cnt2, i + 1, i < 3 ? i + 1 : 3);
         end
      end
      inp = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (match !== 1'b0 || match_cnt2 !== 2'd3) begin
         failures++;
         $display("FAIL b2b_zero m=%b cnt2=%0d exp m=0 cnt2=3", match, match_cnt2);
      end
   endtask

   task automatic test_rst_mid();
      logic [15:0] mv;
      cfg_load = 1'b1;
      cfg_pat  = 8'b0010_1101;
      cfg_len  = 4'd6;
      tick();
      cfg_load = 1'b0;
      send(16'b101, 3, mv);
      checks++;
      if (mv[2:0] !== 3'b000) begin
         failures++;
         $display("FAIL rst_pre got=%b exp=000", mv[2:0]);
      end
      #3 rst = 1'b0;
      #1;
      checks++;
      if (match_cnt !== 8'd0 || state !== 1'b0 || match_cnt2 !== 2'd0) begin
         failures++;
         $display("FAIL rst_async cnt=%0d st=%b cnt2=%0d exp 0 0 0",
                  match_cnt, state, match_cnt2);
      end
      #2 rst = 1'b1;
      send(16'b1011, 4, mv);
      checks++;
      if (mv[3:0] !== 4'b0001 || match_cnt !== 8'd1) begin
         failures++;
         $display("FAIL rst_post got=%b cnt=%0d exp=0001 cnt=1",
                  mv[3:0], match_cnt);
      end
   endtask

   task automatic test_clear_cfg();
      logic [15:0] mv;
      overlap = 1'b1;
      send(16'b101, 3, mv);
      clear    = 1'b1;
      cfg_load = 1'b1;
      cfg_pat  = 8'b0000_0110;
      cfg_len  = 4'd3;
      in_valid = 1'b1;
      inp      = 1'b1;
      tick();
      clear    = 1'b0;
      cfg_load = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (match !== 1'b0 || match_cnt !== 8'd0 || state !== 1'b0) begin
         failures++;
         $display("FAIL clr_cfg m=%b cnt=%0d st=%b exp 0 0 0",
                  match, match_cnt, state);
      end
      send(16'b11011, 5, mv);
      checks++;
      if (mv[4:0] !== 5'b00001 || match_cnt !== 8'd1) begin
         failures++;
         $display("FAIL clr_oldpat got=%b cnt=%0d exp=00001 cnt=1",
                  mv[4:0], match_cnt);
      end
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      inp      = 1'b0;
      overlap  = 1'b1;
      cfg_load = 1'b0;
      cfg_pat  = '0;
      cfg_len  = '0;
      clear    = 1'b0;
      test_reset();
      test_default();
      test_overlap();
      test_gaps();
      test_cfg();
      test_back_to_back();
      test_rst_mid();
      test_clear_cfg();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
